// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus between fetch_ctrl (master) and memory (slave).
// A raised request holds its address until the acknowledge cycle; there is no abort.
interface fetch_ctrl_if;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;

    modport master (
        output im_req,
        output im_addr,
        input  im_ack,
        input  im_rdata
    );

    modport slave (
        input  im_req,
        input  im_addr,
        output im_ack,
        output im_rdata
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns the fetch PC, next-PC priority and the non-abortable imem port.
// Optional feature: define FETCH_WFI_EN to let WFI park the fetcher in SLEEP until an interrupt.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         interrupt,
    input  logic [31:0]  trap_pc,
    input  logic         mret_valid,
    input  logic [31:0]  mret_pc,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    input  logic         loadUse,
    input  logic         dstall,
    input  logic         isWFI,
    fetch_ctrl_if.master im,
    output logic [31:0]  pc_o,
    output logic [31:0]  instr_o,
    output logic [1:0]   instr_sel,
    output logic         fetch_stall
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_DRAIN,
        ST_SLEEP
    } state_t;

    localparam logic [1:0] SEL_FRESH  = 2'b00;
    localparam logic [1:0] SEL_HOLD   = 2'b01;
    localparam logic [1:0] SEL_BUBBLE = 2'b10;

    state_t      r_state;
    logic [31:0] r_pc_f;
    logic [31:0] r_pend_pc;
    logic [31:0] r_pc_o;
    logic [31:0] r_instr;
    logic [1:0]  r_sel;
    logic        r_req;
    logic        r_wfi_pend;

    logic [31:0] w_tgt;
    logic [31:0] w_tgt_al;
    logic        w_tgt_valid;
    logic        w_hold;
    logic        w_wfi_req;
    logic        w_wfi;

`ifdef FETCH_WFI_EN
    assign w_wfi_req = isWFI;
`else
    logic w_unused_wfi;
    assign w_wfi_req    = 1'b0;
    assign w_unused_wfi = isWFI;
`endif

    // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        w_tgt = redirect_pc;
        if (interrupt) begin
            w_tgt = trap_pc;
        end else if (mret_valid) begin
            w_tgt = mret_pc;
        end
    end

    assign w_tgt_valid = interrupt | mret_valid | redirect_valid;
    assign w_tgt_al    = {w_tgt[31:2], 2'b00};
    assign w_hold      = loadUse | dstall;
    assign w_wfi       = w_wfi_req | r_wfi_pend;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_BOOT;
            r_pc_f     <= {RESET_PC[31:2], 2'b00};
            r_pend_pc  <= {RESET_PC[31:2], 2'b00};
            r_pc_o     <= 32'h0;
            r_instr    <= NOP;
            r_sel      <= SEL_BUBBLE;
            r_req      <= 1'b0;
            r_wfi_pend <= 1'b0;
        end else begin
            r_sel <= SEL_BUBBLE;
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_FETCH;
                    r_req   <= 1'b1;
                    if (w_tgt_valid) begin
                        r_pc_f <= w_tgt_al;
                    end
                end
                ST_FETCH: begin
                    if (im.im_ack) begin
                        if (w_tgt_valid) begin
                            r_pc_f     <= w_tgt_al;
                            r_wfi_pend <= 1'b0;
                        end else if (w_wfi) begin
                            r_state    <= ST_SLEEP;
                            r_req      <= 1'b0;
                            r_wfi_pend <= 1'b0;
                        end else if (w_hold) begin
                            r_sel <= SEL_HOLD;
                        end else begin
                            r_pc_o <= r_pc_f;
                            r_instr <= im.im_rdata;
                            r_sel  <= SEL_FRESH;
                            r_pc_f <= r_pc_f + 32'd4;
                        end
                    end else if (w_tgt_valid) begin
                        // Request in flight cannot be cancelled; park the target until it completes.
                        r_pend_pc  <= w_tgt_al;
                        r_state    <= ST_DRAIN;
                        r_wfi_pend <= 1'b0;
                    end else if (w_wfi_req) begin
                        r_wfi_pend <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (im.im_ack) begin
                        r_pc_f  <= w_tgt_valid ? w_tgt_al : r_pend_pc;
                        r_state <= ST_FETCH;
                    end else if (w_tgt_valid) begin
                        r_pend_pc <= w_tgt_al;
                    end
                end
                ST_SLEEP: begin
                    if (interrupt) begin
                        r_pc_f  <= {trap_pc[31:2], 2'b00};
                        r_req   <= 1'b1;
                        r_state <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_BOOT;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign im.im_req   = r_req;
    assign im.im_addr  = r_pc_f;
    assign pc_o        = r_pc_o;
    assign instr_o     = r_instr;
    assign instr_sel   = r_sel;
    assign fetch_stall = ((r_state == ST_FETCH) || (r_state == ST_DRAIN)) && r_req && !im.im_ack;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios then random traffic against a
// transaction-level reference model; memory returns addr ^ 32'hA5A5_0000.
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;
`ifdef FETCH_WFI_EN
    localparam bit WFI_EN = 1'b1;
`else
    localparam bit WFI_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        interrupt, mret_valid, redirect_valid, loadUse, dstall, isWFI;
    logic [31:0] trap_pc, mret_pc, redirect_pc;
    logic [31:0] pc_o, instr_o;
    logic [1:0]  instr_sel;
    logic        fetch_stall;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_ctrl_if bus ();

    fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .interrupt      (interrupt),
        .trap_pc        (trap_pc),
        .mret_valid     (mret_valid),
        .mret_pc        (mret_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .loadUse        (loadUse),
        .dstall         (dstall),
        .isWFI          (isWFI),
        .im             (bus),
        .pc_o           (pc_o),
        .instr_o        (instr_o),
        .instr_sel      (instr_sel),
        .fetch_stall    (fetch_stall)
    );

    always #5 clk = ~clk;

    // Reference model: what the bus should be serving and what the IF/ID pair should show.
    bit          m_live, m_stale, m_asleep, m_wfi;
    logic [31:0] m_pend;
    logic        e_req;
    logic [31:0] e_addr, e_pc_o, e_instr;
    logic [1:0]  e_sel;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_live = 0; m_stale = 0; m_asleep = 0; m_wfi = 0; m_pend = 32'h0;
        e_req = 1'b0; e_addr = 32'h0; e_pc_o = 32'h0; e_instr = NOP; e_sel = 2'b10;
    endtask

    task automatic clear_pulses();
        interrupt = 0; mret_valid = 0; redirect_valid = 0;
        loadUse = 0; dstall = 0; isWFI = 0;
    endtask

    task automatic check_outputs(input string where);
        check({where, ".im_req"},    {31'b0, bus.im_req}, {31'b0, e_req});
        check({where, ".im_addr"},   bus.im_addr,         e_addr);
        check({where, ".pc_o"},      pc_o,                e_pc_o);
        check({where, ".instr_o"},   instr_o,             e_instr);
        check({where, ".instr_sel"}, {30'b0, instr_sel},  {30'b0, e_sel});
    endtask

    // One clock cycle: called at posedge+1 with control inputs already set.
    task automatic cyc(input bit ack);
        logic        a;
        logic        tv;
        logic [31:0] tgt;
        a = ack & e_req;
        bus.im_ack   = a;
        bus.im_rdata = a ? (bus.im_addr ^ KEY) : $urandom();
        #1;
        check("fetch_stall", {31'b0, fetch_stall}, {31'b0, e_req & ~a});

        tv  = interrupt | mret_valid | redirect_valid;
        tgt = interrupt ? trap_pc : (mret_valid ? mret_pc : redirect_pc);
        tgt = tgt & 32'hFFFF_FFFC;
        e_sel = 2'b10;
        if (!m_live) begin
            m_live = 1;
            e_req  = 1'b1;
            if (tv) e_addr = tgt;
        end else if (m_asleep) begin
            if (interrupt) begin
                m_asleep = 0;
                e_req    = 1'b1;
                e_addr   = trap_pc & 32'hFFFF_FFFC;
            end
        end else if (m_stale) begin
            if (tv) m_pend = tgt;
            if (a) begin
                e_addr  = m_pend;
                m_stale = 0;
            end
        end else if (a) begin
            if (tv) begin
                e_addr = tgt;
                m_wfi  = 0;
            end else if (WFI_EN && (isWFI || m_wfi)) begin
                e_req    = 1'b0;
                m_asleep = 1;
                m_wfi    = 0;
            end else if (loadUse || dstall) begin
                e_sel = 2'b01;
            end else begin
                e_pc_o  = e_addr;
                e_instr = e_addr ^ KEY;
                e_sel   = 2'b00;
                e_addr  = e_addr + 32'd4;
            end
        end else if (tv) begin
            m_stale = 1;
            m_pend  = tgt;
            m_wfi   = 0;
        end else if (WFI_EN && isWFI) begin
            m_wfi = 1;
        end

        @(posedge clk);
        #1;
        check_outputs("cyc");
        clear_pulses();
    endtask

    initial begin
        rst = 1'b1;
        clear_pulses();
        trap_pc = 0; mret_pc = 0; redirect_pc = 0;
        bus.im_ack = 1'b0;
        bus.im_rdata = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        check("reset.fetch_stall", {31'b0, fetch_stall}, 32'h0);
        rst = 1'b0;

        // Boot then back-to-back fetches 0x0, 0x4, 0x8 with same-cycle ack.
        cyc(1); cyc(1); cyc(1);
        // Ack at 0x8 delayed three cycles.
        cyc(0); cyc(0); cyc(0); cyc(1);
        cyc(1);
        // loadUse on the ack of 0x10: refetch.
        loadUse = 1; cyc(1);
        cyc(1);
        // Redirect two cycles before a delayed ack: stale word dropped.
        redirect_valid = 1; redirect_pc = 32'h0000_0100; cyc(0);
        cyc(0);
        cyc(1);
        cyc(1);
        // Trap and redirect together: trap wins.
        interrupt = 1; trap_pc = 32'h0000_0200; redirect_valid = 1; redirect_pc = 32'h0000_0300; cyc(1);
        cyc(1);
        // mret with unaligned target.
        mret_valid = 1; mret_pc = 32'h0000_0043; cyc(1);
        cyc(1);
        // Sequential wrap past the top of the address space.
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC; cyc(1);
        cyc(1); cyc(1);
        // Data-side stall holds.
        dstall = 1; cyc(1);
        cyc(1);
        // WFI while a request is outstanding, then wake on interrupt.
        isWFI = 1; cyc(0);
        cyc(0); cyc(1);
        cyc(1); cyc(1);
        interrupt = 1; trap_pc = 32'h0000_0280; cyc(0);
        cyc(1); cyc(1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            interrupt      = ($urandom_range(0, 99) < 3);
            mret_valid     = ($urandom_range(0, 99) < 4);
            redirect_valid = ($urandom_range(0, 99) < 8);
            trap_pc        = $urandom();
            mret_pc        = $urandom();
            redirect_pc    = $urandom();
            loadUse        = ($urandom_range(0, 99) < 10);
            dstall         = ($urandom_range(0, 99) < 5);
            isWFI          = ($urandom_range(0, 99) < 2);
            cyc($urandom_range(0, 99) < 65);
        end

        // Reset in the middle of an outstanding request.
        interrupt = 1; trap_pc = 32'h0000_0400; cyc(0);
        bus.im_ack = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("midreset");
        check("midreset.fetch_stall", {31'b0, fetch_stall}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1); cyc(1); cyc(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch stage controller that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC and the next-PC priority logic (trap, mret, branch/jump redirect, load-use hold, sequential +4). It drives a request/acknowledge instruction-memory port that can never be aborted. It presents a registered `pc_o`/`instr_o` pair plus an `instr_sel` code and a `fetch_stall` flag, which the IF/ID register consumes.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP`, default 32'h0000_0013: bubble instruction (`addi x0,x0,0`).

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `interrupt`  in  1: take trap this cycle, go to `trap_pc`.
- `trap_pc`  in  32: trap vector (mtvec).
- `mret_valid`  in  1: return from trap.
- `mret_pc`  in  32: mepc.
- `redirect_valid`  in  1: branch taken or jump resolved.
- `redirect_pc`  in  32: branch/jump target.
- `loadUse`  in  1: downstream cannot accept a new instruction this cycle.
- `dstall`  in  1: data-side bus stall; freezes PC advance.
- `isWFI`  in  1: WFI decoded.
- `im_req`  out  1: instruction-memory request.
- `im_addr`  out  32: request address, word aligned.
- `im_ack`  in  1: response valid this cycle; may be asserted in the same cycle as `im_req`.
- `im_rdata`  in  32: instruction word, valid with `im_ack`.
- `pc_o`  out  32: PC of `instr_o`.
- `instr_o`  out  32: fetched instruction.
- `instr_sel`  out  2: 00 fresh, 01 hold previous, 10 bubble.
- `fetch_stall`  out  1: request outstanding with no ack; drives `busStall[0]`.

## Operation
- States:
  - BOOT: one cycle after reset, `im_req`=0.
  - FETCH: request `pc_f`.
  - DRAIN: an outstanding request has been made stale by a redirect.
  - SLEEP: WFI.
- Bus rule: once `im_req` rises, `im_req` and `im_addr` hold constant until the `im_ack` cycle. There is no abort.
- Next-PC priority, evaluated every cycle: `interrupt` > `mret_valid` > `redirect_valid` > hold (`loadUse` or `dstall`) > `pc_f+4`. Adder wraps modulo 2^32. `im_addr[1:0]` is always 0; target bits [1:0] are forced to 0.
- FETCH with `im_ack` and no redirect/hold:
  - `pc_o`<=`pc_f`, `instr_o`<=`im_rdata`, `instr_sel`<=00.
  - `pc_f`<=`pc_f+4`; `im_req` stays high (back-to-back).
- FETCH with `im_ack` and hold: the response is discarded, `pc_f` is unchanged (refetch), and `instr_sel`<=01.
- FETCH with `im_ack` and redirect/trap/mret: the response is discarded, `pc_f`<=target, `instr_sel`<=10; stay in FETCH.
- FETCH with no `im_ack` and redirect/trap/mret: `pend_pc`<=target and go to DRAIN.
- DRAIN:
  - A newer redirect overwrites `pend_pc`, using the same priority.
  - On `im_ack`: discard data, `pc_f`<=`pend_pc`, go to FETCH.
  - `instr_sel`=10 throughout.
- Any cycle with no accepted response: `instr_sel`=10, and `pc_o`/`instr_o` hold their value.
- `fetch_stall` = (FETCH or DRAIN) and `im_req` and !`im_ack`.

## Timing
- Reset values: `im_req`=0, `im_addr`=`RESET_PC`, `pc_f`=`RESET_PC`, `pc_o`=0, `instr_o`=`NOP`, `instr_sel`=10, `fetch_stall`=0, state BOOT.
- BOOT to FETCH after exactly one cycle; `im_req` rises in the first cycle after reset deassertion + 1.
- Latency: the `im_ack` cycle N produces `pc_o`/`instr_o` valid from N+1.
- Peak throughput: 1 instruction per cycle with same-cycle ack.
- Redirect at cycle N with `im_ack` at N: the target request is issued at N+1.
- Redirect at cycle N with ack at M>N: the target request is issued at M+1.
- Reset asserted mid-transaction: immediate return to reset values. The outstanding request is abandoned because the bus resets with the core.
- `interrupt` and `redirect_valid` in the same cycle: `trap_pc` wins.

## Configuration
- `FETCH_WFI_EN` defined:
  - FETCH with `isWFI` and no pending redirect: finish any outstanding request, discard its data, then enter SLEEP with `im_req`=0, `instr_sel`=10.
  - SLEEP exits on `interrupt` to FETCH at `trap_pc`.
- `FETCH_WFI_EN` undefined: `isWFI` is ignored, SLEEP is unreachable, and fetch continues sequentially.

## Test plan
- Reset release, always-ack memory returning addr^32'hA5A5_0000 → requests 0x0, 0x4, 0x8 on consecutive cycles; `pc_o` follows one cycle after each ack; `instr_sel`=10 until the first ack.
- Ack delayed 3 cycles at 0x8 → `fetch_stall`=1 for 3 cycles; `im_addr` stable at 0x8; `pc_o` holds 0x4.
- Redirect to 0x100 two cycles before a delayed ack → DRAIN; stale word discarded; next `im_addr`=0x100 on the cycle after ack.
- `loadUse` on the ack of 0x10 → `instr_sel`=01; refetch 0x10; `pc_o` stays 0xC.
- `interrupt`+`redirect_valid` together, `trap_pc`=0x200 → next request 0x200.
- `FETCH_WFI_EN` set, `isWFI` pulse → `im_req`=0 after the outstanding ack; `interrupt` → request at `trap_pc`. Macro clear → fetch continues at +4.
